// File: rtl/keypad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : keypad_decoder
// Description : Debounces a scanned 4x4 keypad, maps the raw row/column index
//               to a key code and queues codes in a 4-entry FIFO with a
//               sticky overflow flag. Define KEYPAD_REPEAT_EN for auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_decoder #(
    parameter int DEB_CYCLES    = 16,
    parameter int REPEAT_CYCLES = 4096
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       D0,
    input  logic       D1,
    input  logic       Q0,
    input  logic       Q1,
    input  logic       OUT,
    output logic [3:0] KEY,
    output logic       IS_DIGIT,
    output logic       KEY_VALID,
    input  logic       KEY_READY,
    output logic       OVERFLOW,
    input  logic       CLR_OVF
);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_deb_press = 2'd1;
    localparam logic [1:0] c_st_held      = 2'd2;
    localparam logic [1:0] c_st_deb_rel   = 2'd3;

    // cnt starts at 1 on entry, so reaching DEB_CYCLES means cnt == DEB_CYCLES-1 now.
    localparam logic [7:0] c_deb_last = 8'(DEB_CYCLES - 1);

    function automatic logic [3:0] code_of(input logic [3:0] idx);
        case (idx)
            4'd0:    code_of = 4'h1;
            4'd1:    code_of = 4'h2;
            4'd2:    code_of = 4'h3;
            4'd3:    code_of = 4'hA;
            4'd4:    code_of = 4'h4;
            4'd5:    code_of = 4'h5;
            4'd6:    code_of = 4'h6;
            4'd7:    code_of = 4'hB;
            4'd8:    code_of = 4'h7;
            4'd9:    code_of = 4'h8;
            4'd10:   code_of = 4'h9;
            4'd11:   code_of = 4'hC;
            4'd12:   code_of = 4'hE;
            4'd13:   code_of = 4'h0;
            4'd14:   code_of = 4'hF;
            default: code_of = 4'hD;
        endcase
    endfunction

    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic [3:0] r_cand;
    logic [3:0] w_idx;
    logic       w_same;
    logic       w_deb_push;
    logic       w_rep_push;
    logic       w_push_req;

    assign w_idx      = {D1, D0, Q1, Q0};
    assign w_same     = OUT && (w_idx == r_cand);
    assign w_deb_push = (r_state == c_st_deb_press) && w_same && (r_cnt == c_deb_last);
    assign w_push_req = w_deb_push || w_rep_push;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= c_st_idle;
            r_cnt   <= 8'd0;
            r_cand  <= 4'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (OUT) begin
                        r_state <= c_st_deb_press;
                        r_cand  <= w_idx;
                        r_cnt   <= 8'd1;
                    end
                end
                c_st_deb_press: begin
                    if (w_same) begin
                        if (r_cnt == c_deb_last) begin
                            r_state <= c_st_held;
                            r_cnt   <= 8'd0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end else begin
                        r_state <= c_st_idle;
                        r_cnt   <= 8'd0;
                    end
                end
                c_st_held: begin
                    if (!OUT) begin
                        r_state <= c_st_deb_rel;
                        r_cnt   <= 8'd1;
                    end
                end
                default: begin
                    if (OUT) begin
                        r_state <= c_st_held;
                        r_cnt   <= 8'd0;
                    end else if (r_cnt == c_deb_last) begin
                        r_state <= c_st_idle;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] c_rep_last = 16'(REPEAT_CYCLES - 1);

    logic [15:0] r_rep_cnt;

    assign w_rep_push = (r_state == c_st_held) && w_same && (r_rep_cnt == c_rep_last);

    // Held at zero outside HELD, so every entry into HELD starts a fresh period.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rep_cnt <= 16'd0;
        end else if ((r_state != c_st_held) || !w_same || w_rep_push) begin
            r_rep_cnt <= 16'd0;
        end else begin
            r_rep_cnt <= r_rep_cnt + 16'd1;
        end
    end
`else
    logic [15:0] w_unused_repeat;

    assign w_rep_push      = 1'b0;
    assign w_unused_repeat = 16'(REPEAT_CYCLES);
`endif

    logic [3:0] r_mem [4];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;
    logic [3:0] r_key;
    logic       r_is_digit;
    logic       r_ovf;

    logic       w_pop;
    logic       w_full;
    logic       w_push;
    logic       w_drop;
    logic [1:0] w_rd_nxt;
    logic [2:0] w_count_nxt;
    logic [3:0] w_push_code;
    logic [3:0] w_head_nxt;

    assign w_pop       = (r_count != 3'd0) && KEY_READY;
    assign w_full      = (r_count == 3'd4);
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_drop      = w_push_req && w_full && !w_pop;
    assign w_rd_nxt    = w_pop ? (r_rd_ptr + 2'd1) : r_rd_ptr;
    assign w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};
    assign w_push_code = code_of(r_cand);
    // The new head may be the entry being written this very cycle.
    assign w_head_nxt  = (w_push && (r_wr_ptr == w_rd_nxt)) ? w_push_code : r_mem[w_rd_nxt];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 4'd0;
            end
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_count    <= 3'd0;
            r_key      <= 4'd0;
            r_is_digit <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_code;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            r_rd_ptr   <= w_rd_nxt;
            r_count    <= w_count_nxt;
            r_key      <= (w_count_nxt != 3'd0) ? w_head_nxt : 4'd0;
            r_is_digit <= (w_count_nxt != 3'd0) && (w_head_nxt <= 4'd9);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (CLR_OVF) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign KEY       = r_key;
    assign IS_DIGIT  = r_is_digit;
    assign KEY_VALID = (r_count != 3'd0);
    assign OVERFLOW  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_keypad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_decoder
// Description : Directed self-checking bench for keypad_decoder (DEB_CYCLES=4,
//               REPEAT_CYCLES=50); repeat checks run when KEYPAD_REPEAT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_decoder;

    logic       CLK;
    logic       RESET;
    logic       D0, D1, Q0, Q1;
    logic       OUT;
    logic [3:0] KEY;
    logic       IS_DIGIT;
    logic       KEY_VALID;
    logic       KEY_READY;
    logic       OVERFLOW;
    logic       CLR_OVF;

    int n_tests = 0;
    int n_fail  = 0;

    keypad_decoder #(
        .DEB_CYCLES    (4),
        .REPEAT_CYCLES (50)
    ) u_dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .D0        (D0),
        .D1        (D1),
        .Q0        (Q0),
        .Q1        (Q1),
        .OUT       (OUT),
        .KEY       (KEY),
        .IS_DIGIT  (IS_DIGIT),
        .KEY_VALID (KEY_VALID),
        .KEY_READY (KEY_READY),
        .OVERFLOW  (OVERFLOW),
        .CLR_OVF   (CLR_OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idx(input logic [3:0] idx);
        {D1, D0, Q1, Q0} = idx;
    endtask

    // Full debounced press (4 cycles) followed by a full debounced release.
    task automatic press(input logic [3:0] idx);
        set_idx(idx);
        OUT = 1'b1;
        cyc(4);
        OUT = 1'b0;
        cyc(6);
    endtask

    initial begin
        RESET     = 1'b0;
        {D1, D0, Q1, Q0} = 4'd0;
        OUT       = 1'b0;
        KEY_READY = 1'b0;
        CLR_OVF   = 1'b0;
        cyc(2);
        check("rst_key",   8'(KEY), 8'h0);
        check("rst_digit", 8'(IS_DIGIT), 8'h0);
        check("rst_valid", 8'(KEY_VALID), 8'h0);
        check("rst_ovf",   8'(OVERFLOW), 8'h0);
        RESET = 1'b1;
        cyc(1);

        // Single press: idx 6 -> code 6, visible one cycle after the 4th stable cycle
        set_idx(4'd6);
        OUT = 1'b1;
        cyc(3);
        check("press_latency", 8'(KEY_VALID), 8'h0);
        cyc(1);
        check("press_valid", 8'(KEY_VALID), 8'h1);
        check("press_key",   8'(KEY), 8'h6);
        check("press_digit", 8'(IS_DIGIT), 8'h1);
`ifndef KEYPAD_REPEAT_EN
        cyc(100);
`endif
        KEY_READY = 1'b1;
        cyc(1);
        KEY_READY = 1'b0;
        check("press_single_event", 8'(KEY_VALID), 8'h0);
        OUT = 1'b0;
        cyc(6);

        // Bounce: 3 high, 1 low, 4 high on idx 13 -> one event, code 0
        set_idx(4'd13);
        OUT = 1'b1;
        cyc(3);
        OUT = 1'b0;
        cyc(1);
        check("bounce_no_early", 8'(KEY_VALID), 8'h0);
        OUT = 1'b1;
        cyc(4);
        check("bounce_valid", 8'(KEY_VALID), 8'h1);
        check("bounce_key",   8'(KEY), 8'h0);
        OUT = 1'b0;
        cyc(6);
        KEY_READY = 1'b1;
        cyc(1);
        KEY_READY = 1'b0;
        check("bounce_one_event", 8'(KEY_VALID), 8'h0);

        // Overflow: five presses with no consumer
        press(4'd0);
        check("fill_head", 8'(KEY), 8'h1);
        press(4'd1);
        press(4'd2);
        press(4'd3);
        check("fill_no_ovf", 8'(OVERFLOW), 8'h0);
        press(4'd14);
        check("ovf_set",  8'(OVERFLOW), 8'h1);
        check("ovf_head", 8'(KEY), 8'h1);
        CLR_OVF = 1'b1;
        cyc(1);
        CLR_OVF = 1'b0;
        check("ovf_clear", 8'(OVERFLOW), 8'h0);
        set_idx(4'd7);
        OUT = 1'b1;
        cyc(3);
        CLR_OVF = 1'b1;
        cyc(1);
        CLR_OVF = 1'b0;
        check("ovf_clr_vs_set", 8'(OVERFLOW), 8'h1);
        OUT = 1'b0;
        cyc(6);
        CLR_OVF = 1'b1;
        cyc(1);
        CLR_OVF = 1'b0;
        check("pop0_key", 8'(KEY), 8'h1);
        KEY_READY = 1'b1;
        cyc(1);
        check("pop1_key", 8'(KEY), 8'h2);
        cyc(1);
        check("pop2_key", 8'(KEY), 8'h3);
        cyc(1);
        check("pop3_key",   8'(KEY), 8'hA);
        check("pop3_digit", 8'(IS_DIGIT), 8'h0);
        cyc(1);
        KEY_READY = 1'b0;
        check("pop_empty", 8'(KEY_VALID), 8'h0);

        // Full FIFO with a pop in the same cycle as the 5th push
        press(4'd0);
        press(4'd1);
        press(4'd2);
        press(4'd3);
        set_idx(4'd14);
        OUT = 1'b1;
        cyc(3);
        KEY_READY = 1'b1;
        cyc(1);
        KEY_READY = 1'b0;
        check("pushpop_no_ovf", 8'(OVERFLOW), 8'h0);
        check("pushpop_head",   8'(KEY), 8'h2);
        OUT = 1'b0;
        cyc(6);
        KEY_READY = 1'b1;
        cyc(1);
        check("pushpop_k3", 8'(KEY), 8'h3);
        cyc(1);
        check("pushpop_kA", 8'(KEY), 8'hA);
        cyc(1);
        check("pushpop_tail", 8'(KEY), 8'hF);
        cyc(1);
        KEY_READY = 1'b0;
        check("pushpop_empty", 8'(KEY_VALID), 8'h0);

        // Reset in the middle of a debounce with a queued entry
        press(4'd6);
        check("prerst_valid", 8'(KEY_VALID), 8'h1);
        set_idx(4'd8);
        OUT = 1'b1;
        cyc(2);
        RESET = 1'b0;
        #1;
        check("midrst_key",   8'(KEY), 8'h0);
        check("midrst_digit", 8'(IS_DIGIT), 8'h0);
        check("midrst_valid", 8'(KEY_VALID), 8'h0);
        check("midrst_ovf",   8'(OVERFLOW), 8'h0);
        cyc(2);
        RESET = 1'b1;
        cyc(3);
        check("postrst_redebounce", 8'(KEY_VALID), 8'h0);
        cyc(1);
        check("postrst_valid", 8'(KEY_VALID), 8'h1);
        check("postrst_key",   8'(KEY), 8'h7);
        OUT = 1'b0;
        cyc(6);
        KEY_READY = 1'b1;
        cyc(1);
        KEY_READY = 1'b0;
        check("postrst_one_event", 8'(KEY_VALID), 8'h0);

`ifdef KEYPAD_REPEAT_EN
        // Hold idx 15 for 4+120 cycles -> initial event plus repeats at 50 and 100
        set_idx(4'd15);
        OUT = 1'b1;
        cyc(4);
        check("rep_first_key", 8'(KEY), 8'hD);
        cyc(120);
        OUT = 1'b0;
        cyc(6);
        KEY_READY = 1'b1;
        cyc(1);
        check("rep_second_valid", 8'(KEY_VALID), 8'h1);
        check("rep_second_key",   8'(KEY), 8'hD);
        cyc(1);
        check("rep_third_valid", 8'(KEY_VALID), 8'h1);
        check("rep_third_key",   8'(KEY), 8'hD);
        cyc(1);
        KEY_READY = 1'b0;
        check("rep_count", 8'(KEY_VALID), 8'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
